// File: rtl/argmax_classifier.sv
// argmax_classifier
//   Streams NUM_CLASS signed scores per frame (class 0 first), picks the
//   highest one (ties go to the higher index) and presents the decision
//   through a valid/ready output. A hangover counter smooths the speech
//   decision into vad_flag, which is updated only when a decision is taken.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   in_data carries a score this cycle
//   in_ready   block accepts a score this cycle (high while scanning)
//   in_data    signed class score, class order 0..NUM_CLASS-1
//   out_valid  frame decision available
//   out_ready  consumer takes the decision
//   out_class  winning class index
//   out_onehot one-hot of out_class
//   out_max    signed winning score
//   vad_flag   hangover-smoothed speech decision
module argmax_classifier #(
    parameter int unsigned NUM_CLASS  = 2,
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned SPEECH_IDX = 1,
    parameter int unsigned HANG_LEN   = 3,
    localparam int unsigned CLS_W     = ($clog2(NUM_CLASS) > 1) ? $clog2(NUM_CLASS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CLS_W-1:0]     out_class,
    output logic [NUM_CLASS-1:0] out_onehot,
    output logic [DATA_W-1:0]    out_max,
    output logic                 vad_flag
);

    typedef enum logic [0:0] {StScan, StHold} state_e;

    state_e                state_q, state_d;
    logic [CLS_W-1:0]      beat_q, beat_d;
    logic [DATA_W-1:0]     best_score_q, best_score_d;
    logic [CLS_W-1:0]      best_idx_q, best_idx_d;
    logic [CLS_W-1:0]      out_class_q, out_class_d;
    logic [NUM_CLASS-1:0]  out_onehot_q, out_onehot_d;
    logic [DATA_W-1:0]     out_max_q, out_max_d;
    logic [7:0]            hang_q, hang_d;
    logic                  vad_q, vad_d;

    logic                  last_beat;
    logic                  take;
    logic [DATA_W-1:0]     cand_score;
    logic [CLS_W-1:0]      cand_idx;
    logic [NUM_CLASS-1:0]  cand_onehot;
    logic                  speech_win;

    // Candidate best after folding in the current beat. Beat 0 always loads,
    // and >= makes a later equal score win the tie.
    always_comb begin
        last_beat  = (beat_q == CLS_W'(NUM_CLASS - 1));
        take       = (beat_q == '0) || ($signed(in_data) >= $signed(best_score_q));
        cand_score = take ? in_data : best_score_q;
        cand_idx   = take ? beat_q : best_idx_q;
        for (int i = 0; i < NUM_CLASS; i++) begin
            cand_onehot[i] = (cand_idx == CLS_W'(i));
        end
        speech_win = (out_class_q == CLS_W'(SPEECH_IDX));
    end

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        best_score_d = best_score_q;
        best_idx_d   = best_idx_q;
        out_class_d  = out_class_q;
        out_onehot_d = out_onehot_q;
        out_max_d    = out_max_q;
        hang_d       = hang_q;
        vad_d        = vad_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;

        unique case (state_q)
            StScan: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    best_score_d = cand_score;
                    best_idx_d   = cand_idx;
                    if (last_beat) begin
                        out_class_d  = cand_idx;
                        out_onehot_d = cand_onehot;
                        out_max_d    = cand_score;
                        beat_d       = '0;
                        state_d      = StHold;
                    end else begin
                        beat_d = beat_q + CLS_W'(1);
                    end
                end
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StScan;
                    // vad uses the hangover count before it is decremented.
                    if (speech_win) begin
                        hang_d = 8'(HANG_LEN);
                        vad_d  = 1'b1;
                    end else begin
                        vad_d = (hang_q != 8'd0);
                        if (hang_q != 8'd0) begin
                            hang_d = hang_q - 8'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = StScan;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StScan;
            beat_q       <= '0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            out_class_q  <= '0;
            out_onehot_q <= '0;
            out_max_q    <= '0;
            hang_q       <= 8'd0;
            vad_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            out_class_q  <= out_class_d;
            out_onehot_q <= out_onehot_d;
            out_max_q    <= out_max_d;
            hang_q       <= hang_d;
            vad_q        <= vad_d;
        end
    end

    assign out_class  = out_class_q;
    assign out_onehot = out_onehot_q;
    assign out_max    = out_max_q;
    assign vad_flag   = vad_q;

endmodule

// File: tb/tb_argmax_classifier.sv
// Testbench for argmax_classifier: a default instance (2 classes, HANG_LEN 3)
// and a 4-class instance. Expected decisions are queued at stimulus time and
// a per-instance monitor pops and compares on every output handshake.
module tb_argmax_classifier;

    localparam int DW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // Default instance
    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_vad;
    logic [DW-1:0] a_in_data, a_out_max;
    logic [0:0]    a_out_class;
    logic [1:0]    a_out_onehot;

    // Four-class instance
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_vad;
    logic [DW-1:0] b_in_data, b_out_max;
    logic [1:0]    b_out_class;
    logic [3:0]    b_out_onehot;

    argmax_classifier u_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_class  (a_out_class),
        .out_onehot (a_out_onehot),
        .out_max    (a_out_max),
        .vad_flag   (a_vad)
    );

    argmax_classifier #(
        .NUM_CLASS  (4)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_class  (b_out_class),
        .out_onehot (b_out_onehot),
        .out_max    (b_out_max),
        .vad_flag   (b_vad)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int cls;
        int oh;
        int mx;
        int vad;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Monitor for the default instance
    int a_vad_pend = 0;
    int a_vad_exp  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            a_vad_pend = 0;
        end else begin
            if (a_vad_pend != 0) begin
                chk("a_vad_flag", a_vad, a_vad_exp);
                a_vad_pend = 0;
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_output: got class %0d, expected no decision",
                             a_out_class);
                end else begin
                    e = qa.pop_front();
                    chk("a_out_class", a_out_class, e.cls);
                    chk("a_out_onehot", a_out_onehot, e.oh);
                    chk("a_out_max", $signed(a_out_max), e.mx);
                    a_vad_exp  = e.vad;
                    a_vad_pend = 1;
                end
            end
        end
    end

    // Monitor for the four-class instance
    int b_vad_pend = 0;
    int b_vad_exp  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            b_vad_pend = 0;
        end else begin
            if (b_vad_pend != 0) begin
                chk("b_vad_flag", b_vad, b_vad_exp);
                b_vad_pend = 0;
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_output: got class %0d, expected no decision",
                             b_out_class);
                end else begin
                    e = qb.pop_front();
                    chk("b_out_class", b_out_class, e.cls);
                    chk("b_out_onehot", b_out_onehot, e.oh);
                    chk("b_out_max", $signed(b_out_max), e.mx);
                    b_vad_exp  = e.vad;
                    b_vad_pend = 1;
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic a_beat(input int d);
        int n = 0;
        while (!a_in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!a_in_ready) begin
            checks++;
            errors++;
            $display("FAIL a_in_ready_timeout: got in_ready 0, expected 1 within 50 cycles");
        end
        a_in_valid = 1'b1;
        a_in_data  = DW'(d);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = '0;
    endtask

    task automatic b_beat(input int d, input int gap);
        int n = 0;
        repeat (gap) begin
            b_in_data = DW'(511); // junk while in_valid is low
            @(posedge clk);
            #1;
        end
        while (!b_in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!b_in_ready) begin
            checks++;
            errors++;
            $display("FAIL b_in_ready_timeout: got in_ready 0, expected 1 within 50 cycles");
        end
        b_in_valid = 1'b1;
        b_in_data  = DW'(d);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_data  = '0;
    endtask

    task automatic a_frame(input int s0, input int s1, input int cls, input int mx,
                           input int vad);
        exp_t e;
        e.cls = cls;
        e.oh  = 1 << cls;
        e.mx  = mx;
        e.vad = vad;
        qa.push_back(e);
        a_beat(s0);
        a_beat(s1);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_class", a_out_class, 0);
        chk("rst_out_onehot", a_out_onehot, 0);
        chk("rst_out_max", a_out_max, 0);
        chk("rst_vad_flag", a_vad, 0);

        // (5, 9) -> class 1, with one-cycle latency check
        e.cls = 1; e.oh = 2; e.mx = 9; e.vad = 1;
        qa.push_back(e);
        a_beat(5);
        chk("lat_valid_after_beat0", a_out_valid, 0);
        a_beat(9);
        chk("lat_valid_after_last", a_out_valid, 1);
        chk("lat_in_ready_hold", a_in_ready, 0);

        // Tie and negatives; hang 3 -> 3 -> 2
        a_frame(-3, -3, 1, -3, 1);
        a_frame(-1, -512, 0, -1, 1);

        // Hangover: S,N,N,N,N
        a_frame(0, 5, 1, 5, 1);
        a_frame(5, 0, 0, 5, 1);
        a_frame(6, -6, 0, 6, 1);
        a_frame(7, 1, 0, 7, 1);
        a_frame(3, 2, 0, 3, 0);

        // Backpressure
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        a_frame(20, -20, 0, 20, 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", a_out_valid, 1);
            chk("bp_in_ready", a_in_ready, 0);
            chk("bp_out_class", a_out_class, 0);
            chk("bp_out_max", $signed(a_out_max), 20);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_after_hs", a_in_ready, 1);
        chk("bp_out_valid_after_hs", a_out_valid, 0);

        // Mid-frame reset discards the partial frame
        a_beat(50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            chk("mfr_out_valid", a_out_valid, 0);
            chk("mfr_in_ready", a_in_ready, 1);
            @(posedge clk);
            #1;
        end
        a_frame(2, 1, 0, 2, 0);

        // Four classes with in_valid gaps
        e.cls = 2; e.oh = 4; e.mx = 12; e.vad = 0;
        qb.push_back(e);
        b_beat(7, 0);
        b_beat(12, 2);
        b_beat(12, 1);
        b_beat(-4, 3);

        // Drain
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || a_vad_pend != 0 || b_vad_pend != 0)
               && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter NUM_CLASS, default 2: classes per frame, legal range 2..16.
REQ-002 SHALL have parameter DATA_W, default 10: signed score width, legal range 2..32.
REQ-003 SHALL have parameter SPEECH_IDX, default 1: class index treated as speech for vad_flag.
REQ-004 SHALL have parameter HANG_LEN, default 3: frames vad_flag is held after the last speech decision, legal range 0..255.
REQ-005 SHALL define localparam CLS_W = max(1, clog2(NUM_CLASS)).
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1: in_data carries a score this cycle.
REQ-009 SHALL have port in_ready, output, 1: block accepts a score this cycle.
REQ-010 SHALL have port in_data, input, DATA_W: signed two's-complement class score, class order 0..NUM_CLASS-1.
REQ-011 SHALL have port out_valid, output, 1: frame decision available.
REQ-012 SHALL have port out_ready, input, 1: consumer takes the decision.
REQ-013 SHALL have port out_class, output, CLS_W: winning class index.
REQ-014 SHALL have port out_onehot, output, NUM_CLASS: one-hot of out_class.
REQ-015 SHALL have port out_max, output, DATA_W: signed winning score.
REQ-016 SHALL have port vad_flag, output, 1: hangover-smoothed speech decision.

Function
REQ-017 SHALL treat a beat as accepted when in_valid && in_ready on a rising edge; the k-th accepted beat of a frame (k=0..NUM_CLASS-1) is class k's score.
REQ-018 SHALL implement FSM states SCAN and HOLD; reset enters SCAN with beat counter 0.
REQ-019 SHALL, in SCAN, drive in_ready=1 and out_valid=0.
REQ-020 SHALL, on beat 0, load best_score=in_data and best_idx=0, unconditionally.
REQ-021 SHALL, on beat k>0, replace best when in_data >= best_score (signed compare), so ties resolve to the higher index.
REQ-022 SHALL, on beat NUM_CLASS-1, register the final decision into out_class/out_onehot/out_max, clear the beat counter, and enter HOLD; out_valid=1 in the next cycle (latency 1 cycle from last accepted beat).
REQ-023 SHALL, in HOLD, drive in_ready=0 and keep out_valid=1 with all out_* stable until out_valid && out_ready.
REQ-024 SHALL, on the out handshake, return to SCAN; in_ready=1 from the following cycle (one bubble cycle per frame minimum).
REQ-025 SHALL ignore in_data when in_valid=0; gaps in in_valid SHALL NOT affect the frame.
REQ-026 SHALL maintain 8-bit hang_cnt updated only on the out handshake: speech win (out_class==SPEECH_IDX) loads HANG_LEN; non-speech decrements if nonzero.
REQ-027 SHALL set vad_flag on the out handshake to 1 on speech win, else to (hang_cnt != 0) evaluated before the decrement; vad_flag is otherwise held.
REQ-028 SHALL, with HANG_LEN=0, make vad_flag equal the latest handshaken decision's speech bit.

Reset
REQ-029 SHALL, while rst=1 at an edge, set state=SCAN, beat counter=0, best_score=0, best_idx=0, out_valid=0, out_class=0, out_onehot=0, out_max=0, hang_cnt=0, vad_flag=0; in_ready=1 after reset deasserts.
REQ-030 SHALL, if rst asserts mid-frame or in HOLD, discard the partial frame or pending decision; no decision for it is ever output.

Verification
REQ-031 SHALL pass defaults: scores (5, 9) -> out_class=1, out_onehot=2'b10, out_max=9, out_valid one cycle after second beat, vad_flag=1 after handshake.
REQ-032 SHALL pass tie and negatives: defaults, scores (-3, -3) -> out_class=1; scores (-1, -512) -> out_class=0, out_max=-1.
REQ-033 SHALL pass NUM_CLASS=4: scores (7, 12, 12, -4) with in_valid gaps -> out_class=2, out_onehot=4'b0100, out_max=12.
REQ-034 SHALL pass backpressure: out_ready=0 for 5 cycles -> out_valid and out_* stable, in_ready=0 throughout; handshake -> in_ready=1 next cycle.
REQ-035 SHALL pass hangover: HANG_LEN=3, decisions S,N,N,N,N (S=speech) -> vad_flag after each handshake 1,1,1,1,0.
REQ-036 SHALL pass mid-frame reset: rst pulsed after beat 0 -> out_valid stays 0, next frame (2, 1) -> out_class=0.
